// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared constants for the FIFO write-port arbiter: default widths, grant ids
// and the saturation limit used by the optional grant counters.
package fifo_arb_pkg;

    localparam int DW_DEF   = 8;
    localparam int CNTW_DEF = 8;

    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

    // All-ones value for a w-bit counter, valid for w in 1..31.
    function automatic logic [31:0] cnt_sat_max(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

    localparam logic [CNTW_DEF-1:0] CNT_SAT_MAX = CNTW_DEF'(cnt_sat_max(CNTW_DEF));

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of the two requester channels, the FIFO write port and the
// last-grant indication. The arbiter uses the slave view; the bench (or the
// surrounding producers/FIFO) uses the master view.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int DW = DW_DEF
) ();

    logic          a_valid;
    logic [DW-1:0] a_data;
    logic          a_ready;
    logic          b_valid;
    logic [DW-1:0] b_data;
    logic          b_ready;
    logic          f_w_ready;
    logic          f_w_valid;
    logic [DW-1:0] f_w_data;
    logic          last_grant;

    modport slave (
        input  a_valid, a_data, b_valid, b_data, f_w_ready,
        output a_ready, b_ready, f_w_valid, f_w_data, last_grant
    );

    modport master (
        output a_valid, a_data, b_valid, b_data, f_w_ready,
        input  a_ready, b_ready, f_w_valid, f_w_data, last_grant
    );

endinterface

// File: rtl/fifo_wr_arbiter_hold.sv
// One-entry holding register between the arbiter and the FIFO write port.
// Reports space when empty or when the held word leaves this cycle, so a new
// word can be loaded in the same cycle the old one drains.
module fifo_arb_hold
    import fifo_arb_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [DW-1:0] load_data_i,
    input  logic          out_ready_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          space_o
);

    logic          hold_valid_q, hold_valid_d;
    logic [DW-1:0] hold_data_q, hold_data_d;
    logic          drain;

    assign drain   = hold_valid_q & out_ready_i;
    assign space_o = ~hold_valid_q | drain;
    assign valid_o = hold_valid_q;
    assign data_o  = hold_data_q;

    // Next state: a load overrides a drain; data is kept after a drain.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (load_i) begin
            hold_valid_d = 1'b1;
            hold_data_d  = load_data_i;
        end else if (drain) begin
            hold_valid_d = 1'b0;
        end
    end

    // Holding register, discarded immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Two-requester round-robin arbiter feeding the single write port of the byte
// FIFO through a one-entry holding register.
// Optional per-requester grant counters are built when FIFO_ARB_STATS_EN is
// defined; without it the stats ports and logic are absent.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int CNTW = CNTW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef FIFO_ARB_STATS_EN
    input  logic            stats_clr,
    output logic [CNTW-1:0] cnt_a,
    output logic [CNTW-1:0] cnt_b,
`endif
    fifo_wr_arbiter_if.slave bus
);

    logic          space;
    logic          fire_a, fire_b;
    logic          rr_q, rr_d;
    logic          load;
    logic [DW-1:0] load_data;

    // Each side's ready looks only at the other side's valid. Ready is held
    // low while reset is asserted so nothing is accepted into a register that
    // is being cleared.
    assign bus.a_ready = rst_n & space & (~bus.b_valid | (rr_q == GNT_B));
    assign bus.b_ready = rst_n & space & (~bus.a_valid | (rr_q == GNT_A));

    assign fire_a    = bus.a_valid & bus.a_ready;
    assign fire_b    = bus.b_valid & bus.b_ready;
    assign load      = fire_a | fire_b;
    assign load_data = fire_a ? bus.a_data : bus.b_data;

    assign bus.last_grant = rr_q;

    fifo_arb_hold #(
        .DW (DW)
    ) u_hold (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load),
        .load_data_i (load_data),
        .out_ready_i (bus.f_w_ready),
        .valid_o     (bus.f_w_valid),
        .data_o      (bus.f_w_data),
        .space_o     (space)
    );

    // Last-granted id moves only when a word is accepted.
    always_comb begin
        rr_d = rr_q;
        if (fire_a) begin
            rr_d = GNT_A;
        end else if (fire_b) begin
            rr_d = GNT_B;
        end
    end

    // Reset to B so A wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= GNT_B;
        end else begin
            rr_q <= rr_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(cnt_sat_max(CNTW));

    logic [CNTW-1:0] cnt_a_q, cnt_a_d;
    logic [CNTW-1:0] cnt_b_q, cnt_b_d;

    // Saturating grant counters; a clear beats an increment in the same cycle.
    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (stats_clr) begin
            cnt_a_d = '0;
            cnt_b_d = '0;
        end else begin
            if (fire_a && (cnt_a_q != CNT_MAX)) cnt_a_d = cnt_a_q + CNTW'(1);
            if (fire_b && (cnt_b_q != CNT_MAX)) cnt_b_d = cnt_b_q + CNTW'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter. A transaction-level model tracks
// whether the holding slot is occupied, which word it holds and who was served
// last; every cycle the DUT outputs are compared against it, and drained words
// are logged for the directed stream checks.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int DW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.DW(DW)) bus ();

`ifdef FIFO_ARB_STATS_EN
    logic       stats_clr;
    logic [7:0] cnt_a, cnt_b;
`endif

    fifo_wr_arbiter #(
        .DW   (DW),
        .CNTW (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef FIFO_ARB_STATS_EN
        .stats_clr (stats_clr),
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b),
`endif
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: slot occupancy, slot contents, requester served last (1 = B).
    bit         m_occ;
    logic [7:0] m_data;
    bit         m_last;
    logic [7:0] drained[$];

    task automatic drive(input bit av, input logic [7:0] ad, input bit bv,
                         input logic [7:0] bd, input bit fr);
        bus.a_valid   = av;
        bus.a_data    = ad;
        bus.b_valid   = bv;
        bus.b_data    = bd;
        bus.f_w_ready = fr;
    endtask

    task automatic model_reset();
        m_occ  = 0;
        m_data = 8'h00;
        m_last = 1;
        drained.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 8'h00, 0, 8'h00, 0);
`ifdef FIFO_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock: entered at posedge+1 with inputs driven; checks mid-cycle,
    // advances the model across the edge and returns at the next posedge+1.
    task automatic step(input string tag, output bit fa, output bit fb);
        bit         slot, ea, eb, fr;
        logic [7:0] ad, bd;
        #4;
        fr   = bus.f_w_ready;
        ad   = bus.a_data;
        bd   = bus.b_data;
        // The slot can take a word if empty or if its word leaves now.
        slot = !m_occ || fr;
        // A side is offered the slot unless the other side also asks and it
        // is the other side's turn (the side not served last).
        ea = slot && (!bus.b_valid || m_last == 1);
        eb = slot && (!bus.a_valid || m_last == 0);
        checks++;
        if (bus.a_ready !== ea) begin
            errors++;
            $display("FAIL %s a_ready: got %b want %b", tag, bus.a_ready, ea);
        end
        checks++;
        if (bus.b_ready !== eb) begin
            errors++;
            $display("FAIL %s b_ready: got %b want %b", tag, bus.b_ready, eb);
        end
        checks++;
        if (bus.f_w_valid !== m_occ) begin
            errors++;
            $display("FAIL %s f_w_valid: got %b want %b", tag, bus.f_w_valid, m_occ);
        end
        checks++;
        if (bus.f_w_data !== m_data) begin
            errors++;
            $display("FAIL %s f_w_data: got %h want %h", tag, bus.f_w_data, m_data);
        end
        checks++;
        if (bus.last_grant !== m_last) begin
            errors++;
            $display("FAIL %s last_grant: got %b want %b", tag, bus.last_grant, m_last);
        end
        if (bus.f_w_valid === 1'b1 && fr) drained.push_back(bus.f_w_data);
        fa = bus.a_valid && ea;
        fb = bus.b_valid && eb;
        @(posedge clk);
        #1;
        if (fa) begin
            m_occ = 1; m_data = ad; m_last = 0;
        end else if (fb) begin
            m_occ = 1; m_data = bd; m_last = 1;
        end else if (m_occ && fr) begin
            m_occ = 0;
        end
    endtask

    task automatic test_reset();
        bit fa, fb;
        rst_n = 1'b0;
        drive(0, 8'h00, 0, 8'h00, 0);
`ifdef FIFO_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got a=%b b=%b want 0 0", bus.a_ready, bus.b_ready);
        end
        rst_n = 1'b1;
        model_reset();
        checks++;
        if (bus.f_w_valid !== 1'b0 || bus.f_w_data !== 8'h00 || bus.last_grant !== 1'b1) begin
            errors++;
            $display("FAIL reset_out: got v=%b d=%h lg=%b want 0 00 1",
                     bus.f_w_valid, bus.f_w_data, bus.last_grant);
        end
        drive(1, 8'h11, 0, 8'h00, 1);
        step("first_a", fa, fb);
        checks++;
        if (fa !== 1'b1 || bus.f_w_valid !== 1'b1 || bus.f_w_data !== 8'h11) begin
            errors++;
            $display("FAIL first_word: got fire=%b v=%b d=%h want 1 1 11", fa, bus.f_w_valid, bus.f_w_data);
        end
        drive(0, 8'h00, 0, 8'h00, 1);
        step("first_idle", fa, fb);
    endtask

    task automatic test_contention();
        bit         fa, fb;
        int         na = 0, nb = 0, fires = 0;
        logic [7:0] exp_q[$];
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1, 8'(8'hA0 + na), 1, 8'(8'hB0 + nb), 1);
            step("contend", fa, fb);
            if (fa) na++;
            if (fb) nb++;
            if (fa || fb) fires++;
        end
        drive(0, 8'h00, 0, 8'h00, 1);
        step("contend_drain", fa, fb);
        step("contend_idle", fa, fb);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'(8'hA0 + i));
            exp_q.push_back(8'(8'hB0 + i));
        end
        checks++;
        if (fires != 10 || drained.size() != 10) begin
            errors++;
            $display("FAIL contend_rate: got fires=%0d drained=%0d want 10 10", fires, drained.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (drained[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL contend_order[%0d]: got %h want %h", i, drained[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_only_b();
        bit fa, fb;
        int fires = 0;
        drained.delete();
        for (int i = 1; i <= 4; i++) begin
            drive(0, 8'h00, 1, 8'(i), 1);
            step("only_b", fa, fb);
            if (fb) fires++;
            checks++;
            if (bus.last_grant !== 1'b1) begin
                errors++;
                $display("FAIL only_b_grant: got %b want 1", bus.last_grant);
            end
        end
        drive(0, 8'h00, 0, 8'h00, 1);
        step("only_b_drain", fa, fb);
        checks++;
        if (fires != 4 || drained.size() != 4 || drained[0] !== 8'h01 || drained[1] !== 8'h02 ||
            drained[2] !== 8'h03 || drained[3] !== 8'h04) begin
            errors++;
            $display("FAIL only_b_stream: got fires=%0d n=%0d want 4 words 01..04", fires, drained.size());
        end
    endtask

    task automatic test_full();
        bit fa, fb;
        do_reset();
        drive(1, 8'h5A, 0, 8'h00, 0);
        step("full_load", fa, fb);
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h61, 1, 8'h62, 0);
            step("full_stall", fa, fb);
            checks++;
            if (bus.f_w_data !== 8'h5A || bus.f_w_valid !== 1'b1 || fa || fb) begin
                errors++;
                $display("FAIL full_hold: got v=%b d=%h fire=%b%b want 1 5a 00",
                         bus.f_w_valid, bus.f_w_data, fa, fb);
            end
        end
        drive(1, 8'h61, 1, 8'h62, 1);
        step("full_release", fa, fb);
        checks++;
        if (fb !== 1'b1 || fa !== 1'b0 || bus.f_w_data !== 8'h62) begin
            errors++;
            $display("FAIL full_refill: got fa=%b fb=%b d=%h want 0 1 62", fa, fb, bus.f_w_data);
        end
        drive(1, 8'h61, 0, 8'h00, 0);
        step("full_after", fa, fb);
    endtask

    task automatic test_reset_mid();
        bit fa, fb;
        // Slot holds a word and the FIFO is stalled.
        drive(0, 8'h00, 0, 8'h00, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.f_w_valid !== 1'b0 || bus.last_grant !== 1'b1 || bus.f_w_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: got v=%b lg=%b d=%h want 0 1 00",
                     bus.f_w_valid, bus.last_grant, bus.f_w_data);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        drive(1, 8'h71, 1, 8'h72, 1);
        step("post_reset", fa, fb);
        checks++;
        if (fa !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_winner: got fa=%b fb=%b want A", fa, fb);
        end
        drive(0, 8'h00, 0, 8'h00, 1);
        step("post_reset_idle", fa, fb);
    endtask

    task automatic test_random();
        bit         fa, fb, av, bv;
        logic [7:0] ad, bd;
        av = 0; bv = 0; ad = 8'h00; bd = 8'h00;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (!av && $urandom_range(0, 2) != 0) begin av = 1; ad = 8'($urandom); end
            if (!bv && $urandom_range(0, 2) != 0) begin bv = 1; bd = 8'($urandom); end
            drive(av, ad, bv, bd, ($urandom_range(0, 3) != 0));
            step("random", fa, fb);
            if (fa) av = 0;
            if (fb) bv = 0;
        end
        drive(0, 8'h00, 0, 8'h00, 1);
        step("random_drain", fa, fb);
    endtask

`ifdef FIFO_ARB_STATS_EN
    task automatic test_stats();
        bit fa, fb;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(1, 8'(i), 0, 8'h00, 1);
            step("stats_fill", fa, fb);
        end
        drive(0, 8'h00, 0, 8'h00, 1);
        step("stats_idle", fa, fb);
        checks++;
        if (cnt_a !== 8'd255 || cnt_b !== 8'd0) begin
            errors++;
            $display("FAIL stats_sat: got a=%0d b=%0d want 255 0", cnt_a, cnt_b);
        end
        stats_clr = 1'b1;
        drive(1, 8'h33, 0, 8'h00, 1);
        step("stats_clr", fa, fb);
        stats_clr = 1'b0;
        checks++;
        if (fa !== 1'b1 || cnt_a !== 8'd0) begin
            errors++;
            $display("FAIL stats_clr_wins: got fire=%b cnt_a=%0d want 1 0", fa, cnt_a);
        end
        drive(0, 8'h00, 0, 8'h00, 1);
        step("stats_end", fa, fb);
    endtask
`endif

    initial begin
        test_reset();
        test_contention();
        test_only_b();
        test_full();
        test_reset_mid();
        test_random();
`ifdef FIFO_ARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
